accum_cpu_core: RTL and testbench
=================================

// Module: accum_cpu_core
// PURPOSE
//  Parametrised accumulator CPU: datapath plus its own fetch/decode/execute FSM.
//  - Holds PC, IR and accumulator A; executes 8-opcode ISA (LOAD/STORE/ADD/SUB/IN/JZ/JPOS/HALT).
//  - Talks to external memory over a req/ack handshake and to an input port over valid/ready.
//  - Adds wait-state tolerance, HALT/start control and single-bit flags.
// PARAMETERS
//  DATA_W  8  accumulator/memory word width; instruction = {opcode[2:0], addr}
//  ADDR_W  5  memory address width; must satisfy ADDR_W <= DATA_W-3 (elaboration-time check)
// PORTS
//  clock      in   1       single clock, rising edge
//  Reset      in   1       asynchronous, active-low reset
//  start      in   1       leave HALT state (ignored in any other state)
//  mem_req    out  1       memory transfer request, held until mem_ack
//  mem_we     out  1       1 = write mem_wdata to mem_addr; valid while mem_req
//  mem_addr   out  ADDR_W  transfer address, stable while mem_req
//  mem_wdata  out  DATA_W  write data (= A)
//  mem_rdata  in   DATA_W  read data, sampled in the mem_ack cycle
//  mem_ack    in   1       transfer complete; ignored while mem_req=0
//  in_data    in   DATA_W  input-port data
//  in_valid   in   1       input data available
//  in_ready   out  1       core waiting on IN; transfer when in_valid & in_ready
//  acc_out    out  DATA_W  accumulator A
//  pc_out     out  ADDR_W  program counter
//  a_zero     out  1       A == 0
//  a_pos      out  1       ~A[DATA_W-1]
//  halted     out  1       core in HALT state
// BEHAVIOUR
//  - Reset low: PC=0, IR=0, A=0, state=HALT; halted=1, mem_req=mem_we=in_ready=0.
//  - Moore outputs: mem_req/mem_we/mem_addr/in_ready/halted decode from the state register.
//  - States:
//    HALT: start=1 -> FETCH.
//    FETCH: req rd @PC; on ack IR<=rdata, PC<=PC+1 (mod 2^ADDR_W) -> DECODE.
//    DECODE:
//      op 000/001/010/011 -> MEM;
//      100 -> INWAIT;
//      101 JZ: if a_zero PC<=IR.addr;
//      110 JPOS: if a_pos PC<=IR.addr;
//      101/110 -> FETCH;
//      111 -> HALT.
//    MEM: req @IR.addr (we=1 only for STORE); on ack:
//      LOAD A<=rdata; ADD A<=A+rdata; SUB A<=A-rdata; STORE no A change; -> FETCH.
//    INWAIT: in_ready=1; on in_valid A<=in_data -> FETCH.
//  - Arithmetic: modulo 2^DATA_W; no carry/overflow kept.
//  - Zero-wait latency (ack in req cycle): LOAD/STORE/ADD/SUB 3 cycles, JZ/JPOS 2, IN 3 min.
//  - Wait states: mem_req, mem_we, mem_addr, mem_wdata held unchanged until ack.
//  - PC wraps 2^ADDR_W-1 -> 0 without error.
//  - Reset asserted mid-transfer aborts it immediately; memory must tolerate a dropped req.
//  - Resuming from HALT continues at the PC following the HALT instruction.
// STRUCTURE
//  - Shared package cpu_pkg: opcode localparams OP_LOAD..OP_HALT, state encoding
//    ST_HALT/FETCH/DECODE/MEM/INWAIT, instruction field slicing macros.
//  - One sub-module accum_alu: inputs a, b, sub; outputs result, zero, neg
//    (purely combinational).
//  - FSM and registers live in accum_cpu_core.
// TESTING (DATA_W=8, ADDR_W=5, behavioural RAM model with programmable ack delay)
//  1 Reset low -> halted=1, mem_req=0, acc_out=0, pc_out=0; release, pulse start
//    -> next cycle mem_req=1, mem_addr=0.
//  2 Program LOAD 10; ADD 11; STORE 12; HALT with M[10]=5, M[11]=3
//    -> M[12]=8, acc_out=8, pc_out=4, halted=1.
//  3 A=3, SUB M=5 -> A=0xFE, a_pos=0 (JPOS not taken); LOAD M=0 then JZ 20
//    -> pc_out=20.
//  4 Ack delayed 3 cycles on every transfer -> req/addr/we/wdata stable throughout;
//    test 2 results unchanged.
//  5 IN with in_valid low 4 cycles -> in_ready held 1;
//    in_data=0x7F on valid cycle -> acc_out=0x7F.
//  6 Instruction at addr 31 (not JZ/JPOS/HALT) -> next fetch at 0;
//    Reset mid-MEM -> mem_req drops at once, all state back to reset values.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU: opcodes, FSM state encoding and
// instruction field slicing (instruction = {opcode[2:0], addr}).
`ifndef CPU_PKG_SV
`define CPU_PKG_SV

`define CPU_IR_OP(ir)        ir[$bits(ir)-1 -: 3]
`define CPU_IR_ADDR(ir, aw)  ir[(aw)-1:0]

package cpu_pkg;

  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_STORE = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_IN    = 3'b100;
  localparam logic [2:0] OP_JZ    = 3'b101;
  localparam logic [2:0] OP_JPOS  = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;

  typedef enum logic [2:0] {
    ST_HALT   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_MEM    = 3'd3,
    ST_INWAIT = 3'd4
  } state_e;

endpackage

`endif

// File: rtl/accum_cpu_core_if.sv
// Memory req/ack bus plus input-port valid/ready, bundled for the CPU core.
// master = core side, slave = memory / input-device side.
interface accum_cpu_core_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, in_ready,
    input  mem_rdata, mem_ack, in_data, in_valid
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, in_ready,
    output mem_rdata, mem_ack, in_data, in_valid
  );
endinterface

// File: rtl/accum_cpu_core_alu.sv
// Combinational add/subtract unit for the accumulator CPU, modulo 2^DATA_W.
// zero/neg describe operand a (the accumulator), feeding JZ/JPOS and the flag outputs.
module accum_alu #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic              i_sub,
  output logic [DATA_W-1:0] o_result,
  output logic              o_zero,
  output logic              o_neg
);
  assign o_result = i_sub ? (i_a - i_b) : (i_a + i_b);
  assign o_zero   = (i_a == '0);
  assign o_neg    = i_a[DATA_W-1];
endmodule

// File: rtl/accum_cpu_core.sv
// Accumulator CPU core: PC/IR/A registers and a fetch/decode/execute FSM that
// talks to memory over req/ack and to an input port over valid/ready.
module accum_cpu_core
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  accum_cpu_core_if.master  bus,
  output logic [DATA_W-1:0] o_acc_out,
  output logic [ADDR_W-1:0] o_pc_out,
  output logic              o_a_zero,
  output logic              o_a_pos,
  output logic              o_halted
);

  if (ADDR_W > DATA_W - 3) begin : g_bad_widths
    $error("accum_cpu_core: ADDR_W must not exceed DATA_W-3");
  end

  state_e            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_pc, w_pc_nxt;
  logic [DATA_W-1:0] r_ir, w_ir_nxt;
  logic [DATA_W-1:0] r_acc, w_acc_nxt;
  logic [2:0]        w_op;
  logic [ADDR_W-1:0] w_ir_addr;
  logic [DATA_W-1:0] w_alu_result;
  logic              w_alu_zero;
  logic              w_alu_neg;

  assign w_op      = `CPU_IR_OP(r_ir);
  assign w_ir_addr = `CPU_IR_ADDR(r_ir, ADDR_W);

  accum_alu #(.DATA_W(DATA_W)) u_alu (
    .i_a      (r_acc),
    .i_b      (bus.mem_rdata),
    .i_sub    (w_op == OP_SUB),
    .o_result (w_alu_result),
    .o_zero   (w_alu_zero),
    .o_neg    (w_alu_neg)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_HALT;
      r_pc    <= '0;
      r_ir    <= '0;
      r_acc   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_ir    <= w_ir_nxt;
      r_acc   <= w_acc_nxt;
    end
  end

  // NOTE: every next-value is defaulted to "hold" first, so no path through
  // the case statement can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_ir_nxt    = r_ir;
    w_acc_nxt   = r_acc;
    case (r_state)
      ST_HALT: if (i_start) w_state_nxt = ST_FETCH;
      ST_FETCH: begin
        if (bus.mem_ack) begin
          w_ir_nxt    = bus.mem_rdata;
          w_pc_nxt    = r_pc + ADDR_W'(1);
          w_state_nxt = ST_DECODE;
        end
      end
      ST_DECODE: begin
        case (w_op)
          OP_LOAD, OP_STORE, OP_ADD, OP_SUB: w_state_nxt = ST_MEM;
          OP_IN:   w_state_nxt = ST_INWAIT;
          OP_JZ: begin
            if (w_alu_zero) w_pc_nxt = w_ir_addr;
            w_state_nxt = ST_FETCH;
          end
          OP_JPOS: begin
            if (!w_alu_neg) w_pc_nxt = w_ir_addr;
            w_state_nxt = ST_FETCH;
          end
          default: w_state_nxt = ST_HALT;
        endcase
      end
      ST_MEM: begin
        if (bus.mem_ack) begin
          case (w_op)
            OP_LOAD:        w_acc_nxt = bus.mem_rdata;
            OP_ADD, OP_SUB: w_acc_nxt = w_alu_result;
            default:        w_acc_nxt = r_acc;
          endcase
          w_state_nxt = ST_FETCH;
        end
      end
      ST_INWAIT: begin
        if (bus.in_valid) begin
          w_acc_nxt   = bus.in_data;
          w_state_nxt = ST_FETCH;
        end
      end
      default: w_state_nxt = ST_HALT;
    endcase
  end

  // Bus outputs decode only from registers, so they stay stable across wait states.
  assign bus.mem_req   = (r_state == ST_FETCH) || (r_state == ST_MEM);
  assign bus.mem_we    = (r_state == ST_MEM) && (w_op == OP_STORE);
  assign bus.mem_addr  = (r_state == ST_MEM) ? w_ir_addr : r_pc;
  assign bus.mem_wdata = r_acc;
  assign bus.in_ready  = (r_state == ST_INWAIT);

  assign o_acc_out = r_acc;
  assign o_pc_out  = r_pc;
  assign o_a_zero  = w_alu_zero;
  assign o_a_pos   = ~w_alu_neg;
  assign o_halted  = (r_state == ST_HALT);

endmodule

// File: tb/tb_accum_cpu_core.sv
// Directed bench for accum_cpu_core: behavioural RAM with programmable ack delay,
// hand-assembled programs and hand-computed results.
module tb_accum_cpu_core;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_start = 1'b0;
  logic [7:0] o_acc_out;
  logic [4:0] o_pc_out;
  logic       o_a_zero;
  logic       o_a_pos;
  logic       o_halted;

  int checks = 0;
  int errors = 0;

  accum_cpu_core_if #(.DATA_W(8), .ADDR_W(5)) bus ();

  accum_cpu_core #(.DATA_W(8), .ADDR_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (i_start),
    .bus       (bus),
    .o_acc_out (o_acc_out),
    .o_pc_out  (o_pc_out),
    .o_a_zero  (o_a_zero),
    .o_a_pos   (o_a_pos),
    .o_halted  (o_halted)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: ack once the request has waited ack_delay cycles.
  logic [7:0] mem [32];
  int         ack_delay = 0;
  int         wait_cnt;
  logic       ld_en = 1'b0;
  logic [4:0] ld_addr = '0;
  logic [7:0] ld_data = '0;

  always_comb begin
    bus.mem_ack   = bus.mem_req && (wait_cnt >= ack_delay);
    bus.mem_rdata = mem[bus.mem_addr];
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) wait_cnt <= 0;
    else if (bus.mem_req && bus.mem_ack) wait_cnt <= 0;
    else if (bus.mem_req) wait_cnt <= wait_cnt + 1;
  end

  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (bus.mem_req && bus.mem_ack && bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
  end

  task automatic load(input logic [4:0] a, input logic [7:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 32; i++) load(5'(i), 8'hE0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; i_start = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Pulses start and returns the number of clock edges until halted (-1 on timeout).
  task automatic run_to_halt(input int max, output int cycles);
    cycles = -1;
    @(negedge clk); i_start = 1'b1;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk); i_start = 1'b0;
      if (o_halted) begin cycles = i; break; end
    end
    if (cycles < 0) begin
      checks++; errors++;
      $display("FAIL run_to_halt: timeout after %0d cycles, required halted=1", max);
    end
  endtask

  // LOAD 10; ADD 11; STORE 12; HALT  with M[10]=5, M[11]=3
  task automatic load_prog_add();
    clear_mem();
    load(5'd0, 8'h0A); load(5'd1, 8'h4B); load(5'd2, 8'h2C); load(5'd3, 8'hE0);
    load(5'd10, 8'd5); load(5'd11, 8'd3);
  endtask

  task automatic test_reset();
    checks++; if (o_halted !== 1'b1) begin errors++; $display("FAIL reset_halted: got %b want 1", o_halted); end
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", bus.mem_req); end
    checks++; if (bus.mem_we !== 1'b0 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_we_ready: got %b/%b want 0/0", bus.mem_we, bus.in_ready); end
    checks++; if (o_acc_out !== 8'h00) begin errors++; $display("FAIL reset_acc: got %h want 00", o_acc_out); end
    checks++; if (o_pc_out !== 5'd0) begin errors++; $display("FAIL reset_pc: got %0d want 0", o_pc_out); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); i_start = 1'b1;
    @(negedge clk); i_start = 1'b0;
    checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 5'd0) begin errors++; $display("FAIL start_fetch: req=%b addr=%0d want req=1 addr=0", bus.mem_req, bus.mem_addr); end
  endtask

  task automatic test_program();
    int cycles;
    ack_delay = 0;
    do_reset();
    load_prog_add();
    run_to_halt(100, cycles);
    checks++; if (mem[12] !== 8'd8) begin errors++; $display("FAIL prog_store: M[12]=%0d want 8", mem[12]); end
    checks++; if (o_acc_out !== 8'd8) begin errors++; $display("FAIL prog_acc: got %0d want 8", o_acc_out); end
    checks++; if (o_pc_out !== 5'd4) begin errors++; $display("FAIL prog_pc: got %0d want 4", o_pc_out); end
    checks++; if (o_halted !== 1'b1 || bus.mem_req !== 1'b0) begin errors++; $display("FAIL prog_halt: halted=%b req=%b want 1/0", o_halted, bus.mem_req); end
    // start + 3 x (3-cycle memory op) + 2-cycle HALT
    checks++; if (cycles != 12) begin errors++; $display("FAIL prog_latency: got %0d cycles want 12", cycles); end
  endtask

  task automatic test_sub_jump();
    int  cycles;
    bit  seen;
    ack_delay = 0;
    do_reset();
    clear_mem();
    // 0 LOAD 10; 1 SUB 11; 2 JPOS 5; 3 HALT; 4 LOAD 12; 5 JZ 20; 20 HALT
    load(5'd0, 8'h0A); load(5'd1, 8'h6B); load(5'd2, 8'hC5); load(5'd3, 8'hE0);
    load(5'd4, 8'h0C); load(5'd5, 8'hB4); load(5'd20, 8'hE0);
    load(5'd10, 8'd3); load(5'd11, 8'd5); load(5'd12, 8'd0);
    run_to_halt(100, cycles);
    checks++; if (o_acc_out !== 8'hFE) begin errors++; $display("FAIL sub_acc: got %h want fe", o_acc_out); end
    checks++; if (o_a_pos !== 1'b0 || o_a_zero !== 1'b0) begin errors++; $display("FAIL sub_flags: pos=%b zero=%b want 0/0", o_a_pos, o_a_zero); end
    checks++; if (o_pc_out !== 5'd4) begin errors++; $display("FAIL jpos_not_taken: pc=%0d want 4", o_pc_out); end
    seen = 0;
    @(negedge clk); i_start = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); i_start = 1'b0;
      if (bus.mem_req && bus.mem_addr == 5'd20) begin seen = 1; break; end
    end
    checks++; if (!seen || o_pc_out !== 5'd20) begin errors++; $display("FAIL jz_taken: seen=%0d pc=%0d want 1/20", seen, o_pc_out); end
    checks++; if (o_a_zero !== 1'b1 || o_acc_out !== 8'h00) begin errors++; $display("FAIL jz_flags: zero=%b acc=%h want 1/00", o_a_zero, o_acc_out); end
    for (int i = 0; i < 10 && !o_halted; i++) @(negedge clk);
    checks++; if (o_halted !== 1'b1 || o_pc_out !== 5'd21) begin errors++; $display("FAIL jz_halt: halted=%b pc=%0d want 1/21", o_halted, o_pc_out); end
  endtask

  task automatic test_wait_states();
    int         cycles = -1;
    int         held = 0;
    bit         hold = 0;
    logic [4:0] s_addr = '0;
    logic       s_we = 1'b0;
    logic [7:0] s_wdata = '0;
    ack_delay = 3;
    do_reset();
    load_prog_add();
    @(negedge clk); i_start = 1'b1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk); i_start = 1'b0;
      if (hold) begin
        held++;
        checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== s_addr || bus.mem_we !== s_we || bus.mem_wdata !== s_wdata) begin
          errors++;
          $display("FAIL wait_stable: req=%b addr=%0d we=%b wdata=%h want 1/%0d/%b/%h",
                   bus.mem_req, bus.mem_addr, bus.mem_we, bus.mem_wdata, s_addr, s_we, s_wdata);
        end
      end
      hold    = bus.mem_req && !bus.mem_ack;
      s_addr  = bus.mem_addr;
      s_we    = bus.mem_we;
      s_wdata = bus.mem_wdata;
      if (o_halted) begin cycles = i; break; end
    end
    checks++; if (held != 21) begin errors++; $display("FAIL wait_count: got %0d held cycles want 21", held); end
    checks++; if (cycles != 33) begin errors++; $display("FAIL wait_latency: got %0d cycles want 33", cycles); end
    checks++; if (mem[12] !== 8'd8 || o_acc_out !== 8'd8 || o_pc_out !== 5'd4) begin
      errors++; $display("FAIL wait_result: M12=%0d acc=%0d pc=%0d want 8/8/4", mem[12], o_acc_out, o_pc_out);
    end
    ack_delay = 0;
  endtask

  task automatic test_in();
    bit seen = 0;
    do_reset();
    clear_mem();
    load(5'd0, 8'h80); load(5'd1, 8'hE0);
    @(negedge clk); i_start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); i_start = 1'b0;
      if (bus.in_ready) begin seen = 1; break; end
    end
    checks++; if (!seen) begin errors++; $display("FAIL in_ready_rise: in_ready never 1, want 1"); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++; if (bus.in_ready !== 1'b1 || o_acc_out !== 8'h00) begin errors++; $display("FAIL in_hold: ready=%b acc=%h want 1/00", bus.in_ready, o_acc_out); end
    end
    bus.in_data = 8'h7F; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0; bus.in_data = 8'h00;
    checks++; if (o_acc_out !== 8'h7F || bus.in_ready !== 1'b0) begin errors++; $display("FAIL in_capture: acc=%h ready=%b want 7f/0", o_acc_out, bus.in_ready); end
    for (int i = 0; i < 10 && !o_halted; i++) @(negedge clk);
    checks++; if (o_halted !== 1'b1 || o_pc_out !== 5'd2 || o_acc_out !== 8'h7F) begin
      errors++; $display("FAIL in_halt: halted=%b pc=%0d acc=%h want 1/2/7f", o_halted, o_pc_out, o_acc_out);
    end
  endtask

  task automatic test_wrap_reset();
    int cycles;
    bit seen = 0;
    ack_delay = 0;
    do_reset();
    clear_mem();
    // 0 JZ 30; 1 HALT; 30 LOAD 10; 31 ADD 11 -> wraps to 0, JZ falls through
    load(5'd0, 8'hBE); load(5'd1, 8'hE0); load(5'd30, 8'h0A); load(5'd31, 8'h4B);
    load(5'd10, 8'h55); load(5'd11, 8'h01);
    run_to_halt(100, cycles);
    checks++; if (o_acc_out !== 8'h56 || o_pc_out !== 5'd2) begin errors++; $display("FAIL pc_wrap: acc=%h pc=%0d want 56/2", o_acc_out, o_pc_out); end
    checks++; if (cycles != 13) begin errors++; $display("FAIL wrap_latency: got %0d cycles want 13", cycles); end

    do_reset();
    ack_delay = 5;
    clear_mem();
    load(5'd0, 8'h0A); load(5'd10, 8'h55);
    @(negedge clk); i_start = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk); i_start = 1'b0;
      if (bus.mem_req && bus.mem_addr == 5'd10) begin seen = 1; break; end
    end
    checks++; if (!seen || o_pc_out !== 5'd1) begin errors++; $display("FAIL mid_mem_reach: seen=%0d pc=%0d want 1/1", seen, o_pc_out); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.mem_req !== 1'b0 || bus.mem_we !== 1'b0 || bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL abort_bus: req=%b we=%b ready=%b want 0/0/0", bus.mem_req, bus.mem_we, bus.in_ready);
    end
    checks++; if (o_halted !== 1'b1 || o_acc_out !== 8'h00 || o_pc_out !== 5'd0) begin
      errors++; $display("FAIL abort_state: halted=%b acc=%h pc=%0d want 1/00/0", o_halted, o_acc_out, o_pc_out);
    end
    @(negedge clk); rst_n = 1'b1; ack_delay = 0;
    @(negedge clk); i_start = 1'b1;
    @(negedge clk); i_start = 1'b0;
    checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 5'd0 || bus.mem_we !== 1'b0) begin
      errors++; $display("FAIL restart_fetch: req=%b addr=%0d we=%b want 1/0/0", bus.mem_req, bus.mem_addr, bus.mem_we);
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    clear_mem();
    test_reset();
    test_program();
    test_sub_jump();
    test_wait_states();
    test_in();
    test_wrap_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
